// File: rtl/vid_timing_pattern_gen.sv
// rtl/vid_timing_pattern_gen.sv - programmable video timing generator with frame-synchronous shadow config and test patterns
// Optional pattern logic (bars/grid/fade/solid) is compiled in with VTPG_PATTERN_EN; otherwise pixels are the latched solid colour.
module vid_timing_pattern_gen #(
    parameter int CNT_W = 12,
    parameter int PIX_W = 8
) (
    input  logic               I_pxl_clk,
    input  logic               I_rst_n,
    input  logic [CNT_W-1:0]   I_h_total,
    input  logic [CNT_W-1:0]   I_h_sync,
    input  logic [CNT_W-1:0]   I_h_bporch,
    input  logic [CNT_W-1:0]   I_h_res,
    input  logic [CNT_W-1:0]   I_v_total,
    input  logic [CNT_W-1:0]   I_v_sync,
    input  logic [CNT_W-1:0]   I_v_bporch,
    input  logic [CNT_W-1:0]   I_v_res,
    input  logic               I_hs_pol,
    input  logic               I_vs_pol,
    input  logic [1:0]         I_mode,
    input  logic [3*PIX_W-1:0] I_solid_rgb,
    output logic               O_de,
    output logic               O_hs,
    output logic               O_vs,
    output logic               O_sof,
    output logic [CNT_W-1:0]   O_x,
    output logic [CNT_W-1:0]   O_y,
    output logic [PIX_W-1:0]   O_data_r,
    output logic [PIX_W-1:0]   O_data_g,
    output logic [PIX_W-1:0]   O_data_b,
    output logic               O_cfg_err
);

    typedef struct packed {
        logic [CNT_W-1:0]   h_total;
        logic [CNT_W-1:0]   h_sync;
        logic [CNT_W-1:0]   h_bporch;
        logic [CNT_W-1:0]   h_res;
        logic [CNT_W-1:0]   v_total;
        logic [CNT_W-1:0]   v_sync;
        logic [CNT_W-1:0]   v_bporch;
        logic [CNT_W-1:0]   v_res;
        logic               hs_pol;
        logic               vs_pol;
        logic [3*PIX_W-1:0] solid;
`ifdef VTPG_PATTERN_EN
        logic [1:0]         mode;
        logic [CNT_W-1:0]   bar_w;
`endif
    } cfg_t;

    cfg_t               cfg_q, cfg_d, cfg_new, cfg_rst;
    logic               load_pend_q, load_pend_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic               cfg_err_q, cfg_err_d;
    logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic [3*PIX_W-1:0] rgb_q, rgb_d, pix_rgb;

    logic [CNT_W:0]     h_sum, v_sum;
    logic               cfg_ok, line_end, frame_end;
    logic [CNT_W-1:0]   h_start, h_end, v_start, v_end, x_pos, y_pos;
    logic               h_act, v_act, h_sync_act, v_sync_act;

    // 1280x720p60 until the first accepted load
    always_comb begin
        cfg_rst          = '0;
        cfg_rst.h_total  = CNT_W'(1650);
        cfg_rst.h_sync   = CNT_W'(40);
        cfg_rst.h_bporch = CNT_W'(220);
        cfg_rst.h_res    = CNT_W'(1280);
        cfg_rst.v_total  = CNT_W'(750);
        cfg_rst.v_sync   = CNT_W'(5);
        cfg_rst.v_bporch = CNT_W'(20);
        cfg_rst.v_res    = CNT_W'(720);
        cfg_rst.hs_pol   = 1'b1;
        cfg_rst.vs_pol   = 1'b1;
`ifdef VTPG_PATTERN_EN
        cfg_rst.bar_w    = CNT_W'(160);
`endif
    end

    always_comb begin
        cfg_new          = '0;
        cfg_new.h_total  = I_h_total;
        cfg_new.h_sync   = I_h_sync;
        cfg_new.h_bporch = I_h_bporch;
        cfg_new.h_res    = I_h_res;
        cfg_new.v_total  = I_v_total;
        cfg_new.v_sync   = I_v_sync;
        cfg_new.v_bporch = I_v_bporch;
        cfg_new.v_res    = I_v_res;
        cfg_new.hs_pol   = I_hs_pol;
        cfg_new.vs_pol   = I_vs_pol;
        cfg_new.solid    = I_solid_rgb;
`ifdef VTPG_PATTERN_EN
        cfg_new.mode     = I_mode;
        cfg_new.bar_w    = I_h_res >> 3;
`endif
        h_sum  = {1'b0, I_h_sync} + {1'b0, I_h_bporch} + {1'b0, I_h_res};
        v_sum  = {1'b0, I_v_sync} + {1'b0, I_v_bporch} + {1'b0, I_v_res};
        cfg_ok = (I_h_res != '0) && (I_v_res != '0) &&
                 (h_sum <= {1'b0, I_h_total}) && (v_sum <= {1'b0, I_v_total});
    end

    // Shadow is always a validated config, so these sums cannot overflow CNT_W
    always_comb begin
        h_start    = cfg_q.h_sync + cfg_q.h_bporch;
        h_end      = h_start + cfg_q.h_res;
        v_start    = cfg_q.v_sync + cfg_q.v_bporch;
        v_end      = v_start + cfg_q.v_res;
        h_act      = (h_cnt_q >= h_start) && (h_cnt_q < h_end);
        v_act      = (v_cnt_q >= v_start) && (v_cnt_q < v_end);
        h_sync_act = h_cnt_q < cfg_q.h_sync;
        v_sync_act = v_cnt_q < cfg_q.v_sync;
        x_pos      = h_cnt_q - h_start;
        y_pos      = v_cnt_q - v_start;
        line_end   = h_cnt_q == cfg_q.h_total - CNT_W'(1);
        frame_end  = line_end && (v_cnt_q == cfg_q.v_total - CNT_W'(1));
    end

`ifdef VTPG_PATTERN_EN
    logic [PIX_W-1:0]   fade_q, fade_d;
    logic [CNT_W-1:0]   wc_q, wc_d;
    logic [3:0]         bar_q, bar_d;
    logic [3*PIX_W-1:0] bar_rgb;

    always_comb begin
        bar_rgb = '0;
        if (!bar_q[3]) begin
            bar_rgb = {{PIX_W{~bar_q[1]}}, {PIX_W{~bar_q[2]}}, {PIX_W{~bar_q[0]}}};
        end
        pix_rgb = cfg_q.solid;
        case (cfg_q.mode)
            2'd0:    pix_rgb = bar_rgb;
            2'd1:    pix_rgb = (x_pos[4:0] == 5'd0 || y_pos[4:0] == 5'd0) ? '1 : '0;
            2'd2:    pix_rgb = {fade_q, ~fade_q, {PIX_W{1'b0}}};
            default: pix_rgb = cfg_q.solid;
        endcase
    end

    // Bar position tracks the pixel currently held in h_cnt_q; bar 8 means past the last bar
    always_comb begin
        fade_d = fade_q;
        wc_d   = wc_q;
        bar_d  = bar_q;
        if (!load_pend_q && frame_end) begin
            fade_d = fade_q + PIX_W'(1);
        end
        if (h_cnt_d == '0) begin
            wc_d  = '0;
            bar_d = (cfg_d.bar_w == '0) ? 4'd8 : 4'd0;
        end else if (h_act && !bar_q[3]) begin
            if (wc_q == cfg_q.bar_w - CNT_W'(1)) begin
                wc_d  = '0;
                bar_d = bar_q + 4'd1;
            end else begin
                wc_d  = wc_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^I_mode;
    assign pix_rgb     = cfg_q.solid;
`endif

    // The cycle after reset is spent loading the shadow; counters hold and outputs stay low
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        cfg_d       = cfg_q;
        cfg_err_d   = cfg_err_q;
        load_pend_d = 1'b0;
        de_d        = 1'b0;
        hs_d        = 1'b0;
        vs_d        = 1'b0;
        sof_d       = 1'b0;
        x_d         = '0;
        y_d         = '0;
        rgb_d       = '0;
        if (load_pend_q || frame_end) begin
            if (cfg_ok) begin
                cfg_d = cfg_new;
            end
            cfg_err_d = ~cfg_ok;
        end
        if (!load_pend_q) begin
            de_d  = h_act && v_act;
            hs_d  = h_sync_act ^ ~cfg_q.hs_pol;
            vs_d  = v_sync_act ^ ~cfg_q.vs_pol;
            sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (de_d) begin
                x_d   = x_pos;
                y_d   = y_pos;
                rgb_d = pix_rgb;
            end
            if (line_end) begin
                h_cnt_d = '0;
                v_cnt_d = frame_end ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            cfg_q       <= cfg_rst;
            load_pend_q <= 1'b1;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            cfg_err_q   <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            sof_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            rgb_q       <= '0;
`ifdef VTPG_PATTERN_EN
            fade_q      <= '0;
            wc_q        <= '0;
            bar_q       <= '0;
`endif
        end else begin
            cfg_q       <= cfg_d;
            load_pend_q <= load_pend_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            cfg_err_q   <= cfg_err_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            sof_q       <= sof_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rgb_q       <= rgb_d;
`ifdef VTPG_PATTERN_EN
            fade_q      <= fade_d;
            wc_q        <= wc_d;
            bar_q       <= bar_d;
`endif
        end
    end

    assign O_de      = de_q;
    assign O_hs      = hs_q;
    assign O_vs      = vs_q;
    assign O_sof     = sof_q;
    assign O_x       = x_q;
    assign O_y       = y_q;
    assign O_data_r  = rgb_q[3*PIX_W-1:2*PIX_W];
    assign O_data_g  = rgb_q[2*PIX_W-1:PIX_W];
    assign O_data_b  = rgb_q[PIX_W-1:0];
    assign O_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_vid_timing_pattern_gen.sv
// tb/tb_vid_timing_pattern_gen.sv - randomized self-checking bench for vid_timing_pattern_gen
// The frame model works from a linear position within the frame and the configuration rules directly.
module tb_vid_timing_pattern_gen;
    localparam int CNT_W = 12;
    localparam int PIX_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CNT_W-1:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic hs_pol, vs_pol;
    logic [1:0] mode;
    logic [23:0] solid;
    logic de, hs, vs, sof, cfg_err;
    logic [CNT_W-1:0] ox, oy;
    logic [PIX_W-1:0] dr, dg, db;

    always #5 clk = ~clk;

    vid_timing_pattern_gen #(.CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_hs_pol(hs_pol), .I_vs_pol(vs_pol), .I_mode(mode), .I_solid_rgb(solid),
        .O_de(de), .O_hs(hs), .O_vs(vs), .O_sof(sof), .O_x(ox), .O_y(oy),
        .O_data_r(dr), .O_data_g(dg), .O_data_b(db), .O_cfg_err(cfg_err)
    );

    typedef struct {
        int ht, hs, hb, hr, vt, vs, vb, vr;
        bit hp, vp;
        int md;
        logic [23:0] sol;
    } cfg_t;

`ifdef VTPG_PATTERN_EN
    localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    int checks = 0, failures = 0, cyc = 0;
    cfg_t sh;
    int pos = 0, fade = 0;
    bit pend = 1'b1;
    bit e_de, e_hs, e_vs, e_sof, e_err;
    int e_x, e_y;
    logic [23:0] e_rgb;

    int n_hs_hi = 0, n_hs_lo = 0, n_vs_lo = 0, n_de = 0;
    int d_hs_hi, d_hs_lo, d_vs_lo, d_de;
    int max_x = 0, max_y = 0, last_sof = 0, sof_gap = 0;
    int last_r = -1, fade_bad = 0;
    bit saw_wrap = 1'b0;
    logic [23:0] bar_cap [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] act_vec();
        return {11'd0, de, hs, vs, sof, cfg_err, ox, oy, dr, dg, db};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {11'd0, e_de, e_hs, e_vs, e_sof, e_err, CNT_W'(e_x), CNT_W'(e_y), e_rgb};
    endfunction

`ifdef VTPG_PATTERN_EN
    function automatic logic [23:0] pixel(input int x, input int y);
        int bw;
        bw = sh.hr / 8;
        case (sh.md)
            0: return (bw != 0 && x < 8 * bw) ? BAR_TAB[x / bw] : 24'h0;
            1: return (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h0;
            2: return {8'(fade), 8'(255 - fade), 8'h00};
            default: return sh.sol;
        endcase
    endfunction
`endif

    task automatic clear_exp();
        e_de = 0; e_hs = 0; e_vs = 0; e_sof = 0; e_x = 0; e_y = 0; e_rgb = '0;
    endtask

    task automatic model_load();
        cfg_t n;
        bit ok;
        n = '{int'(h_total), int'(h_sync), int'(h_bporch), int'(h_res),
              int'(v_total), int'(v_sync), int'(v_bporch), int'(v_res),
              hs_pol, vs_pol, int'(mode), solid};
        ok = n.hr != 0 && n.vr != 0 && n.hs + n.hb + n.hr <= n.ht && n.vs + n.vb + n.vr <= n.vt;
        if (ok) sh = n;
        e_err = !ok;
    endtask

    task automatic model_step();
        int h, v, hst, vst;
        if (!rst_n) begin
            pos = 0; pend = 1; fade = 0; e_err = 0;
            sh = '{1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1, 0, 24'h0};
            clear_exp();
        end else if (pend) begin
            pend = 0;
            model_load();
            clear_exp();
        end else begin
            h = pos % sh.ht;
            v = pos / sh.ht;
            hst = sh.hs + sh.hb;
            vst = sh.vs + sh.vb;
            e_hs  = (h < sh.hs) == sh.hp;
            e_vs  = (v < sh.vs) == sh.vp;
            e_sof = pos == 0;
            e_de  = h >= hst && h < hst + sh.hr && v >= vst && v < vst + sh.vr;
            e_x   = e_de ? h - hst : 0;
            e_y   = e_de ? v - vst : 0;
`ifdef VTPG_PATTERN_EN
            e_rgb = e_de ? pixel(h - hst, v - vst) : 24'h0;
`else
            e_rgb = e_de ? sh.sol : 24'h0;
`endif
            if (pos == sh.ht * sh.vt - 1) begin
                model_load();
                fade = (fade + 1) % 256;
                pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("outputs", act_vec(), exp_vec());
        cyc++;
        if (hs) n_hs_hi++; else n_hs_lo++;
        if (!vs) n_vs_lo++;
        if (de) begin
            n_de++;
            if (int'(ox) > max_x) max_x = int'(ox);
            if (int'(oy) > max_y) max_y = int'(oy);
            if (oy == 0 && ox < 32) bar_cap[ox[4:0]] = {dr, dg, db};
            if (ox == 0 && oy == 0 && mode == 2'd2) begin
                if (last_r >= 0 && int'(dr) != (last_r + 1) % 256) fade_bad++;
                if (last_r == 255 && dr == 0) saw_wrap = 1'b1;
                last_r = int'(dr);
            end
        end
        if (sof) begin
            sof_gap = cyc - last_sof;
            last_sof = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_sof();
        int i;
        i = 0;
        do begin
            cycle();
            i++;
        end while (!sof && i < 5000);
        check("sof_seen", {63'd0, sof}, 64'd1);
    endtask

    task automatic frame_stats();
        int s_hi, s_lo, s_vlo, s_de;
        wait_sof();
        s_hi = n_hs_hi; s_lo = n_hs_lo; s_vlo = n_vs_lo; s_de = n_de;
        max_x = 0; max_y = 0;
        wait_sof();
        d_hs_hi = n_hs_hi - s_hi; d_hs_lo = n_hs_lo - s_lo;
        d_vs_lo = n_vs_lo - s_vlo; d_de = n_de - s_de;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        check("reset_outputs", act_vec(), 64'd0);
        rst_n = 1'b1;
        cycle();
        check("sof_load_cycle", {63'd0, sof}, 64'd0);
        cycle();
        check("sof_after_release", {63'd0, sof}, 64'd1);
    endtask

    task automatic set_small(input int hr);
        h_total = 10; h_sync = 2; h_bporch = 2; h_res = CNT_W'(hr);
        v_total = 6; v_sync = 1; v_bporch = 1; v_res = 3;
    endtask

    task automatic rand_cfg(input bit force_valid);
        int a, b, c, p, q, r;
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(1, 12);
        p = $urandom_range(0, 3); q = $urandom_range(0, 3); r = $urandom_range(1, 8);
        h_sync = CNT_W'(a); h_bporch = CNT_W'(b); h_res = CNT_W'(c);
        h_total = CNT_W'(a + b + c + int'($urandom_range(0, 4)));
        v_sync = CNT_W'(p); v_bporch = CNT_W'(q); v_res = CNT_W'(r);
        v_total = CNT_W'(p + q + r + int'($urandom_range(0, 3)));
        if (!force_valid && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
                0: h_res = '0;
                1: h_total = CNT_W'(a + b + c - 1);
                default: v_total = CNT_W'(p + q + r - 1);
            endcase
        end
    endtask

    initial begin
        set_small(4);
        hs_pol = 1'b1; vs_pol = 1'b1; mode = 2'd3; solid = 24'h123456;
        do_reset();

        frame_stats();
        check("sof_period", 64'(sof_gap), 64'd60);
        check("hs_high_per_frame", 64'(d_hs_hi), 64'd12);
        check("de_per_frame", 64'(d_de), 64'd12);
        check("x_max", 64'(max_x), 64'd3);
        check("y_max", 64'(max_y), 64'd2);

        hs_pol = 1'b0; vs_pol = 1'b0;
        frame_stats();
        check("hs_low_pol0", 64'(d_hs_lo), 64'd12);
        check("vs_low_pol0", 64'(d_vs_lo), 64'd10);

        hs_pol = 1'b1; vs_pol = 1'b1;
        wait_sof();
        run(5);
        h_res = 2;
        begin
            int s;
            s = n_de;
            wait_sof();
            check("de_frame_of_change", 64'(n_de - s), 64'd12);
        end
        frame_stats();
        check("de_after_change", 64'(d_de), 64'd6);
        check("x_max_after_change", 64'(max_x), 64'd1);

        h_sync = 4; h_bporch = 4; h_res = 4;
        wait_sof();
        check("cfg_err_set", {63'd0, cfg_err}, 64'd1);
        frame_stats();
        check("old_timing_kept", 64'(d_de), 64'd6);
        set_small(4);
        wait_sof();
        check("cfg_err_clear", {63'd0, cfg_err}, 64'd0);
        frame_stats();
        check("de_valid_again", 64'(d_de), 64'd12);

`ifdef VTPG_PATTERN_EN
        h_total = 20; h_res = 16; mode = 2'd0;
        frame_stats();
        for (int k = 0; k < 8; k++) begin
            check("bar_colour_a", 64'(bar_cap[2 * k]), 64'(BAR_TAB[k]));
            check("bar_colour_b", 64'(bar_cap[2 * k + 1]), 64'(BAR_TAB[k]));
        end
        mode = 2'd1;
        frame_stats();
        set_small(4);
        mode = 2'd2;
        wait_sof();
        wait_sof();
        last_r = -1; fade_bad = 0; saw_wrap = 1'b0;
        run(260 * 60);
        check("fade_step", 64'(fade_bad), 64'd0);
        check("fade_wrap", {63'd0, saw_wrap}, 64'd1);
`endif

        set_small(4);
        mode = 2'd3;
        wait_sof();
        run(23);
        do_reset();
        frame_stats();
        check("sof_period_after_reset", 64'(sof_gap), 64'd60);
        check("de_after_reset", 64'(d_de), 64'd12);

        for (int it = 0; it < 60; it++) begin
            rand_cfg(1'b0);
            hs_pol = 1'($urandom); vs_pol = 1'($urandom);
            mode = 2'($urandom); solid = 24'($urandom);
            run($urandom_range(20, 400));
            if ($urandom_range(0, 9) == 0) begin
                rand_cfg(1'b1);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
